// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width plus the fetch-stage
// NOP encoding and FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP} fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order buffer of {pc, instr} between instruction memory and the
// IF/ID register. Slot 0 is always the head; flush wins over push/pop.
module fetch_queue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic [31:0]     push_instr_i,
  output logic [XLEN-1:0] head_pc_o,
  output logic [31:0]     head_instr_o,
  output logic [1:0]      count_o
);

  logic [XLEN-1:0] pc_q    [2];
  logic [31:0]     instr_q [2];
  logic [1:0]      count_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      count_q <= 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc_q[0]    <= push_pc_i;
            instr_q[0] <= push_instr_i;
          end else begin
            pc_q[1]    <= push_pc_i;
            instr_q[1] <= push_instr_i;
          end
          if (count_q != 2'd2) count_q <= count_q + 2'd1;
        end
        2'b01: begin
          pc_q[0]    <= pc_q[1];
          instr_q[0] <= instr_q[1];
          count_q    <= count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new entry lands behind whatever survives.
          if (count_q == 2'd2) begin
            pc_q[0]    <= pc_q[1];
            instr_q[0] <= instr_q[1];
            pc_q[1]    <= push_pc_i;
            instr_q[1] <= push_instr_i;
          end else begin
            pc_q[0]    <= push_pc_i;
            instr_q[0] <= push_instr_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_pc_o    = pc_q[0];
  assign head_instr_o = instr_q[0];
  assign count_o      = count_q;

endmodule

// File: rtl/fetch.sv
// RV32I instruction-fetch stage: owns the fetch PC, keeps one imem request in
// flight, buffers responses and feeds InstrF/PCF/PCPlus4F to IF/ID.
module fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            ValidF,
  output fetch_state_e    state_o
);

  // imem handshake: imem_req is a one-cycle pulse carrying imem_addr; exactly
  // one imem_rvalid returns per request, in order, at least a cycle later.
  fetch_state_e    state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] req_pc_q;

  logic            push;
  logic            pop;
  logic            room;
  logic [2:0]      occ_next;
  logic [1:0]      count;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;

  assign ValidF   = (count != 2'd0);
  assign push     = (state_q == F_WAIT) && imem_rvalid && !PCSrcE;
  assign pop      = ValidF && !StallF && !PCSrcE;
  assign occ_next = {1'b0, count} + {2'b00, push} - {2'b00, pop};
  assign room     = (occ_next < 3'd2);
  assign imem_req = room && !PCSrcE &&
                    ((state_q == F_IDLE) || ((state_q == F_WAIT) && imem_rvalid));
  assign imem_addr = fetch_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= F_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else if (PCSrcE) begin
      fetch_pc_q <= PCTargetE;
      // An in-flight request becomes stale; DROP swallows its response.
      if (state_q != F_IDLE) state_q <= imem_rvalid ? F_IDLE : F_DROP;
    end else if (imem_req) begin
      req_pc_q   <= fetch_pc_q;
      fetch_pc_q <= fetch_pc_q + XLEN'(4);
      state_q    <= F_WAIT;
    end else if (imem_rvalid && (state_q != F_IDLE)) begin
      state_q <= F_IDLE;
    end
  end

  fetch_queue #(.XLEN(XLEN)) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (PCSrcE),
    .push_pc_i    (req_pc_q),
    .push_instr_i (imem_rdata),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (count)
  );

  assign InstrF   = ValidF ? head_instr : NOP_INSTR;
  assign PCF      = ValidF ? head_pc : '0;
  assign PCPlus4F = ValidF ? head_pc + XLEN'(4) : '0;
  assign state_o  = state_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a variable-latency imem model plus a
// queue-based reference of the fetch stage, driven by directed and random steps.
module tb_fetch;
  import riscv_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic         StallF;
  logic         PCSrcE;
  logic [31:0]  PCTargetE;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic [31:0]  InstrF;
  logic [31:0]  PCF;
  logic [31:0]  PCPlus4F;
  logic         ValidF;
  fetch_state_e state_o;

  always #5 clk = ~clk;

  fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .ValidF      (ValidF),
    .state_o     (state_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference: fetched-but-unconsumed instructions, the next address to ask
  // for, and whether a response is owed (and whether it is stale).
  ent_t        m_q[$];
  logic [31:0] m_next_pc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_disc;

  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          last_req;

  int n_cmp = 0;
  int n_bad = 0;

  // addi x1, x0, imm with an address-derived immediate.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[13:2] ^ a[25:14], 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_next_pc = RESET_PC;
    m_req_pc  = '0;
    m_out     = 1'b0;
    m_disc    = 1'b0;
    mem_busy  = 1'b0;
    last_req  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    @(posedge clk);
    #1;
    check("rst_req",    32'(imem_req), 32'd1);
    check("rst_addr",   imem_addr, RESET_PC);
    check("rst_instr",  InstrF, NOP_INSTR);
    check("rst_pcf",    PCF, 32'h0);
    check("rst_pc4",    PCPlus4F, 32'h0);
    check("rst_valid",  32'(ValidF), 32'd0);
    check("rst_state",  32'(state_o), 32'(F_IDLE));
  endtask

  task automatic step(input bit r, input bit stall, input bit redir, input logic [31:0] tgt);
    bit           got;
    bit           pop;
    bit           exp_req;
    int           occ;
    fetch_state_e exp_st;
    @(negedge clk);
    rst         = r;
    StallF      = stall;
    PCSrcE      = redir;
    PCTargetE   = tgt;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!r && mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_busy    = 1'b0;
      end
    end
    #1;
    if (r) begin
      model_reset();
      return;
    end

    exp_st = !m_out ? F_IDLE : (m_disc ? F_DROP : F_WAIT);
    check("state", 32'(state_o), 32'(exp_st));
    check("ValidF", 32'(ValidF), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("PCF",      PCF, m_q[0].pc);
      check("PCPlus4F", PCPlus4F, m_q[0].pc + 32'd4);
      check("InstrF",   InstrF, m_q[0].instr);
    end else begin
      check("PCF_empty",      PCF, 32'h0);
      check("PCPlus4F_empty", PCPlus4F, 32'h0);
      check("InstrF_empty",   InstrF, NOP_INSTR);
    end

    got     = imem_rvalid && m_out && !m_disc;
    pop     = (m_q.size() > 0) && !stall;
    occ     = m_q.size() + int'(got) - int'(pop);
    exp_req = !redir && (occ < 2) && (!m_out || got);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_next_pc);

    if (imem_req) begin
      check("one_outstanding", 32'(mem_busy), 32'd0);
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
    end
    last_req = imem_req;

    if (redir) begin
      m_q.delete();
      m_next_pc = tgt;
      if (m_out) begin
        if (imem_rvalid) begin
          m_out  = 1'b0;
          m_disc = 1'b0;
        end else begin
          m_disc = 1'b1;
        end
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (got) m_q.push_back(ent_t'({m_req_pc, mem_word(m_req_pc)}));
      if (imem_rvalid && m_out) begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
      if (exp_req) begin
        m_req_pc  = m_next_pc;
        m_next_pc = m_next_pc + 32'd4;
        m_out     = 1'b1;
        m_disc    = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Advance until the DUT has just issued a request, within a cycle budget.
  task automatic wait_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      seen = last_req;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    bit          found;
    logic [31:0] tgt;
    rst         = 1'b1;
    StallF      = 1'b0;
    PCSrcE      = 1'b0;
    PCTargetE   = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    model_reset();

    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_reset_outputs();

    // Back-to-back fetch from a 1-cycle memory.
    lat_lo = 1; lat_hi = 1;
    run(12);

    // Hold the decode side for 4 cycles, then release.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    run(8);

    // Redirect while a 3-cycle request is still in flight.
    lat_lo = 3; lat_hi = 3;
    wait_req("wait_req_drop");
    step(1'b0, 1'b0, 1'b1, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (ValidF) begin
        found = 1'b1;
        check("drop_first_pc", PCF, 32'h100);
      end
    end
    check("drop_timeout", 32'(found), 32'd1);
    run(10);

    // Redirect in the same cycle as a response.
    lat_lo = 1; lat_hi = 1;
    wait_req("wait_req_same");
    step(1'b0, 1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("same_flush_instr", InstrF, NOP_INSTR);
    check("same_next_addr",   imem_addr, 32'h200);
    run(6);

    // Address wrap at the top of the 32-bit space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    run(8);

    // Reset while a slow request is outstanding.
    lat_lo = 3; lat_hi = 3;
    wait_req("wait_req_rst");
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_reset_outputs();
    run(10);

    // Randomised latency, stalls and redirects.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 600; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
      step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the RV32I pipeline: the producer side of the IF/ID interface that the decode stage consumes. Owns the fetch PC and issues word requests to instruction memory, keeping at most one request outstanding. Buffers returned instructions in a 2-entry fetch queue. Presents `InstrF`/`PCF`/`PCPlus4F` to the IF/ID register, honouring `StallF` and redirects from execute (`PCSrcE`/`PCTargetE`).

## Interface
- `XLEN`, default `riscv_pkg::XLEN`: address/data width.
- `RESET_PC`, default `'0`: first fetch address. Must be word-aligned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `StallF` in 1: hazard unit holds the IF/ID input; do not pop the queue.
- `PCSrcE` in 1: taken branch/jump redirect from execute.
- `PCTargetE` in XLEN: redirect target, word-aligned.
- `imem_req` out 1: one-cycle request pulse.
- `imem_addr` out XLEN: request address, valid with `imem_req`.
- `imem_rvalid` in 1: response strobe. Exactly one per request, in order, at least 1 cycle after the request.
- `imem_rdata` in 32: instruction word, valid with `imem_rvalid`.
- `InstrF` out 32: queue-head instruction, or NOP `32'h0000_0013` when the queue is empty.
- `PCF` out XLEN: queue-head PC, or 0 when empty.
- `PCPlus4F` out XLEN: `PCF + 4` when valid, or 0 when empty.
- `ValidF` out 1: queue non-empty.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - `req_pc`: address of the outstanding request.
  - state, one of IDLE, WAIT, DROP.
  - 2-entry queue of {pc, instr} with a count of 0..2.
- `push` = `imem_rvalid` in WAIT and `!PCSrcE`.
- `pop` = `ValidF & !StallF & !PCSrcE`.
- `room` = (count + push − pop) < 2.
- `imem_req` = `room & !PCSrcE & (state==IDLE | (state==WAIT & imem_rvalid))`. It is combinational; `imem_addr = fetch_pc`.
- On issue: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4` (wraps modulo 2^XLEN), next state WAIT.
- Transitions:
  - IDLE, no issue: stay IDLE.
  - WAIT, `imem_rvalid`, no redirect: push; go to WAIT if a new request is issued, else IDLE.
  - WAIT, no `imem_rvalid`, no redirect: stay WAIT.
  - WAIT, `PCSrcE`, `imem_rvalid` the same cycle: discard the response, go to IDLE.
  - WAIT, `PCSrcE`, no `imem_rvalid`: go to DROP.
  - DROP, `imem_rvalid`: discard the response, go to IDLE.
  - DROP, otherwise: stay DROP.
- Redirect (`PCSrcE`=1) in any state:
  - queue flushed (count <= 0);
  - `fetch_pc <= PCTargetE`;
  - no request, no push, no pop that cycle.
  - A redirect in DROP only updates `fetch_pc`.
- Redirect has priority over `StallF` and over a simultaneous response.
- `StallF` with a full queue: no request issued. Queue contents and outputs are held stable.
- Push and pop in the same cycle: count unchanged, order preserved.

## Timing
- Reset values:
  - state IDLE, count 0, `fetch_pc = RESET_PC`, `req_pc = 0`.
  - Outputs follow: `imem_req` asserted in the first cycle after reset release, with `imem_addr = RESET_PC`.
  - `InstrF = 32'h13`, `PCF = 0`, `PCPlus4F = 0`, `ValidF = 0`.
- Fetch latency with a 1-cycle memory:
  - request in cycle t, response in t+1;
  - the instruction is visible on `InstrF` in t+2.
- Steady-state throughput is 1 instruction per cycle with a 1-cycle memory and no stall.
- Redirect in cycle t: the target request is issued in t+1 from IDLE. From DROP it is issued in the cycle after the stale response arrives.
- `rst` mid-request: the FSM returns to IDLE immediately. A later stale `imem_rvalid` arriving in IDLE is ignored (no push).

## Structure
- `riscv_pkg` additions:
  - `localparam logic [31:0] NOP_INSTR = 32'h0000_0013`;
  - `typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP} fetch_state_e`.
- Sub-module `fetch_queue`: parameterised 2-entry synchronous FIFO of {XLEN pc, 32 instr}.
  - Inputs: push, pop, flush.
  - Outputs: head, count.
  - Flush has priority.
- FSM, PC registers and request logic live in `fetch`.

## Test plan
- Reset release, `RESET_PC=0`, 1-cycle memory returning `addi` words: requests to 0, 4, 8 on consecutive cycles. `PCF` = 0, 4, 8 from cycle 2, with `ValidF` high continuously.
- `StallF` held 4 cycles: queue fills to 2 and `imem_req` drops. `PCF` is held. After release, PCs resume in order with none lost or duplicated.
- `PCSrcE` with `PCTargetE=0x100` while WAIT and no `imem_rvalid`: enter DROP. The stale response is discarded and `imem_addr=0x100` is issued after it. The first valid `PCF` afterwards is 0x100.
- `PCSrcE` in the same cycle as `imem_rvalid`: the response is not pushed. Queue empty, `InstrF=0x13`, next `imem_addr=PCTargetE`.
- 3-cycle memory latency: one request in flight only, and `ValidF` pulses once every 3 cycles with the correct PC/instruction pairing.
- `fetch_pc=0xFFFF_FFFC` with XLEN=32: the next request address wraps to 0.
